// File: rtl/mini_core_ifetch.sv
// Instruction fetch: issues sequential word reads, buffers {pc, inst} pairs in a FIFO for decode.
// Optional MINI_CORE_IFETCH_BYPASS_EN presents a live return directly when the FIFO is empty.
module mini_core_ifetch #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clock,
  input  logic              Rst,
  output logic [ADDR_W-1:0] imem_address,
  output logic              imem_rden,
  input  logic [31:0]       imem_q,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        issue, ret_live, fifo_empty, fifo_push, fifo_pop, bypass;
  logic [31:0] redirect_base, issue_pc;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_base = {redirect_pc[31:2], 2'b00};
  assign fifo_empty    = (count_q == '0);
  assign ret_live      = inflight_q & ~redirect_valid;

  // Credit uses registered occupancy only, so a same-cycle pop never funds an issue.
  assign issue = redirect_valid |
                 ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
  assign issue_pc     = redirect_valid ? redirect_base : fetch_pc_q;
  assign imem_address = issue_pc[ADDR_W+1:2];
  assign imem_rden    = issue & ~Rst;

  always_comb begin
    bypass = 1'b0;
`ifdef MINI_CORE_IFETCH_BYPASS_EN
    bypass = fifo_empty & ret_live;
`else
    bypass = 1'b0;
`endif
    inst_valid = ~redirect_valid & (~fifo_empty | bypass);
    inst       = '0;
    inst_pc    = '0;
    if (inst_valid) begin
      if (bypass) begin
        inst    = imem_q;
        inst_pc = inflight_pc_q;
      end else begin
        inst    = fifo_inst_q[rd_ptr_q];
        inst_pc = fifo_pc_q[rd_ptr_q];
      end
    end
    fifo_pop  = inst_valid & inst_ready & ~bypass;
    fifo_push = ret_live & ~(bypass & inst_ready);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (issue) begin
      fetch_pc_d    = issue_pc + 32'd4;
      inflight_pc_d = issue_pc;
    end
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) begin
      fetch_pc_q    <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_inst_q[wr_ptr_q] <= imem_q;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: doc/mini_core_ifetch.md
Name: mini_core_ifetch

Overview:
- Instruction-fetch initiator that drives the core read port of the instruction memory and buffers the returned words.
- Generates sequential word addresses and absorbs the memory's fixed 1-cycle registered read latency.
- Stores {pc, instruction} pairs in a small FIFO and presents them to the decode stage over a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- PC_RESET, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, minimum 2.
- ADDR_W, MSB_I_MEM-1, word-address width driven to the memory.

Ports:
- clock  in  1  core clock.
- Rst  in  1  asynchronous reset, active-high.
- imem_address  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
- imem_rden  out  1  read enable, one read per asserted cycle.
- imem_q  in  32  read data, valid the cycle after imem_rden.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0).
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  decode accepts the head entry.
- inst  out  32  instruction; 0 when inst_valid=0.
- inst_pc  out  32  PC of inst; 0 when inst_valid=0.

Behaviour:
- Reset (async, Rst=1):
  - fetch_pc=PC_RESET, FIFO empty, in-flight flag clear.
  - imem_rden=0, inst_valid=0, inst=0, inst_pc=0.
  - The first read issues in the first cycle after Rst deasserts.
- Issue rule: imem_rden=1 when fifo_count + inflight < FIFO_DEPTH, using registered values only. A same-cycle pop earns no credit, so the FIFO never overflows.
- On issue:
  - Record the issued PC in the in-flight register.
  - fetch_pc <= fetch_pc+4, modulo 2^32. Address wrap follows naturally from truncation to ADDR_W.
- Return: the cycle after an issue, {inflight_pc, imem_q} is pushed into the FIFO tail, unless the return is killed by a redirect.
- Sustained throughput: 1 instruction/cycle while inst_ready=1.
- Pop: inst_valid & inst_ready removes the head.
- Simultaneous push and pop: count unchanged. Push into a full FIFO cannot occur by construction; the bench asserts this.
- Redirect cycle (redirect_valid=1):
  - FIFO is emptied at the clock edge.
  - A return arriving in this cycle is dropped.
  - inst_valid is forced to 0 this cycle; an inst_ready pop is ignored.
  - A read is issued this cycle at address redirect_pc[ADDR_W+1:2] (combinational mux); credit is full after the flush.
  - fetch_pc <= {redirect_pc[31:2],2'b00} + 4.
- Back-to-back redirects: the latest one wins. Each issued read is killed only by a redirect in its return cycle.
- Reset mid-operation: all state is discarded immediately; a pending return is ignored.
- Latency:
  - Issue to inst_valid: 2 cycles (FIFO write, then head visible).
  - Redirect to first valid redirected instruction: 2 cycles.
- Order: strictly in PC order; there is never a gap in pc between consecutive entries except across a redirect.

Optional Feature:
- Macro: MINI_CORE_IFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, a return is live, and redirect_valid=0, the return is presented directly this cycle (inst_valid=1, inst=imem_q, inst_pc=inflight_pc).
  - If inst_ready=1, it is consumed and not written to the FIFO.
  - Otherwise it is written to the FIFO as normal.
  - Issue-to-valid latency drops to 1 cycle.
- Undefined: every return goes through the FIFO; latency is 2 cycles.

Test Plan:
- Reset release, PC_RESET=0, memory word n = 32'h1000_0000+n, inst_ready=1 → imem_address 0,1,2,3…; inst_valid first at cycle 2; inst/inst_pc = (32'h1000_0000,0), (32'h1000_0001,4), … one per cycle.
- inst_ready=0 after release → exactly 4 reads issued (addresses 0–3), then imem_rden=0. Raise inst_ready → PCs 0,4,8,12 drain in order and issue resumes at address 4.
- Redirect to 32'h0000_0103 on cycle 6 with a FIFO holding 2 entries → inst_valid=0 that cycle; same-cycle imem_address=0x40; the next valid entries are inst_pc=0x100, then 0x104. No stale PCs appear.
- Redirect on cycles 5 and 6 (0x200, then 0x300) → first valid inst_pc=0x300; 0x200 never appears at the output.
- fetch_pc at (2^ADDR_W−1)*4 → imem_address wraps to 0 and inst_pc continues +4 without a stall.
- With MINI_CORE_IFETCH_BYPASS_EN, reset release, inst_ready=1 → first inst_valid at cycle 1 with inst_pc=0. Async Rst pulse mid-stream → inst_valid=0 immediately, restart at PC_RESET.
